// File: rtl/arps_mb_scheduler.sv
// Frame-level macroblock sequencer for the ARPS motion-estimation core: raster walk, engine handshake, MV BRAM writes.
// Optional abort input enabled by defining ARPS_SCHED_ABORT_EN.
module arps_mb_scheduler #(
    parameter int          FRAME_W_MB   = 16,
    parameter int          FRAME_H_MB   = 16,
    parameter logic [31:0] MV_ADDR_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
`ifdef ARPS_SCHED_ABORT_EN
    input  logic        abort_i,
`endif
    output logic        ready_o,
    output logic        mb_start_o,
    output logic [7:0]  mb_x_o,
    output logic [7:0]  mb_y_o,
    input  logic        mb_done_i,
    input  logic [7:0]  mv_x_i,
    input  logic [7:0]  mv_y_i,
    output logic [31:0] addr_mv_o,
    output logic [31:0] data_mv_o,
    output logic        en_mv_o,
    output logic [3:0]  we_mv_o,
    output logic [15:0] mb_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic abort;
`ifdef ARPS_SCHED_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    logic        last_col, last_row;
    logic [31:0] mb_index;

    assign last_col = (mb_x_o == 8'(FRAME_W_MB - 1));
    assign last_row = (mb_y_o == 8'(FRAME_H_MB - 1));
    assign mb_index = 32'(mb_y_o) * 32'(FRAME_W_MB) + 32'(mb_x_o);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every variable assigned in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (mb_done_i) state_d = S_WRITE;
            S_WRITE: state_d = S_NEXT;
            S_NEXT:  state_d = (last_col && last_row) ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every other transition.
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    logic        ready_d, start_d, en_d;
    logic [7:0]  x_d, y_d;
    logic [15:0] count_d;
    logic [31:0] addr_d, data_d;

    // Outputs are derived from the next state and then registered, so they line up with the state they describe.
    always_comb begin
        ready_d = (state_d == S_IDLE);
        start_d = (state_d == S_ISSUE);
        en_d    = (state_d == S_WRITE);
        x_d     = mb_x_o;
        y_d     = mb_y_o;
        count_d = mb_count_o;
        addr_d  = addr_mv_o;
        data_d  = data_mv_o;
        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            x_d     = 8'd0;
            y_d     = 8'd0;
            count_d = 16'd0;
        end
        if (state_q == S_WAIT && state_d == S_WRITE) begin
            addr_d = MV_ADDR_BASE + (mb_index << 2);
            data_d = {{8{mv_y_i[7]}}, mv_y_i, {8{mv_x_i[7]}}, mv_x_i};
        end
        if (state_q == S_WRITE && !abort) count_d = mb_count_o + 16'd1;
        // Coordinates advance only when another macroblock follows; after the last one they hold.
        if (state_q == S_NEXT && state_d == S_ISSUE) begin
            if (last_col) begin
                x_d = 8'd0;
                y_d = mb_y_o + 8'd1;
            end else begin
                x_d = mb_x_o + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o    <= 1'b1;
            mb_start_o <= 1'b0;
            mb_x_o     <= 8'd0;
            mb_y_o     <= 8'd0;
            addr_mv_o  <= 32'd0;
            data_mv_o  <= 32'd0;
            en_mv_o    <= 1'b0;
            we_mv_o    <= 4'h0;
            mb_count_o <= 16'd0;
        end else begin
            ready_o    <= ready_d;
            mb_start_o <= start_d;
            mb_x_o     <= x_d;
            mb_y_o     <= y_d;
            addr_mv_o  <= addr_d;
            data_mv_o  <= data_d;
            en_mv_o    <= en_d;
            we_mv_o    <= {4{en_d}};
            mb_count_o <= count_d;
        end
    end

endmodule
